system_bus_responder: RTL and testbench

SYSTEM_BUS_RESPONDER -- requirements
Module: system_bus_responder

---
 rtl/system_bus_responder.sv | 102 ++++++++++
 tb/tb_system_bus_responder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/system_bus_responder.sv
// rtl/system_bus_responder.sv - word-addressed memory responder with byte-lane writes and credit-limited in-order read responses
// Reads flow through one registered memory stage into a response FIFO; ready is granted only while the FIFO can absorb every read in flight.
module system_bus_responder #(
  parameter int ADDR_BITS  = 10,
  parameter int RESP_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        system_bus_ready,
  input  logic [31:2] system_bus_addr,
  input  logic [3:0]  system_bus_byte_enable,
  input  logic [31:0] system_bus_write_data,
  input  logic        system_bus_write_req,
  input  logic        system_bus_read_req,
  output logic [31:0] system_bus_read_data,
  output logic        system_bus_read_data_valid,
  input  logic        system_bus_read_data_ready
);

  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [31:0]          mem [0:(1 << ADDR_BITS) - 1];
  logic [ADDR_BITS-1:0] word_addr;
  logic                 unused_addr_bits;

  logic                 running;
  logic                 s1_valid;
  logic [31:0]          s1_data;

  logic [31:0]          fifo_data [0:RESP_DEPTH-1];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;

  logic                 accept_wr;
  logic                 accept_rd;
  logic                 push;
  logic                 pop;
  logic [31:0]          merged;

  assign word_addr        = system_bus_addr[ADDR_BITS+1:2];
  assign unused_addr_bits = ^system_bus_addr[31:ADDR_BITS+2];

  // Credit covers both buffered entries and the read sitting in the memory stage.
  assign system_bus_ready = running && ((count + CW'(s1_valid)) < CW'(RESP_DEPTH));

  assign accept_wr = system_bus_ready && system_bus_write_req;
  assign accept_rd = system_bus_ready && system_bus_read_req;
  assign push      = s1_valid;
  assign pop       = (count != '0) && system_bus_read_data_ready;

  assign system_bus_read_data_valid = (count != '0);
  assign system_bus_read_data       = fifo_data[rd_ptr];

  // Write-first: a read accepted with a write sees the merged word.
  always_comb begin
    merged = mem[word_addr];
    for (int i = 0; i < 4; i++) begin
      if (accept_wr && system_bus_byte_enable[i]) begin
        merged[8*i +: 8] = system_bus_write_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept_wr) begin
      mem[word_addr] <= merged;
    end
    if (accept_rd) begin
      s1_data <= merged;
    end
    if (push) begin
      fifo_data[wr_ptr] <= s1_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      running  <= 1'b0;
      s1_valid <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      running  <= 1'b1;
      s1_valid <= accept_rd;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_system_bus_responder.sv
// tb/tb_system_bus_responder.sv - self-checking bench for system_bus_responder
// A queue-based model of accepted reads predicts ready/valid/data every cycle; directed steps add literal expectations.
module tb_system_bus_responder;

  localparam int ADDR_BITS  = 10;
  localparam int RESP_DEPTH = 4;
  localparam int MW         = 1 << ADDR_BITS;

  logic        clk;
  logic        reset;
  logic        bus_ready;
  logic [31:2] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        wr;
  logic        rd;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rdy;

  int checks;
  int errors;

  system_bus_responder #(.ADDR_BITS(ADDR_BITS), .RESP_DEPTH(RESP_DEPTH)) dut (
    .clk                        (clk),
    .reset                      (reset),
    .system_bus_ready           (bus_ready),
    .system_bus_addr            (addr),
    .system_bus_byte_enable     (be),
    .system_bus_write_data      (wdata),
    .system_bus_write_req       (wr),
    .system_bus_read_req        (rd),
    .system_bus_read_data       (rdata),
    .system_bus_read_data_valid (rvalid),
    .system_bus_read_data_ready (rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: every accepted-but-unconsumed read is one queue entry, visible from the edge after acceptance.
  typedef struct {
    bit [31:0] data;
    bit        known;
    int        avail;
  } resp_t;

  resp_t     q[$];
  bit [31:0] mmem [MW];
  bit        mknown [MW];
  bit        m_running;
  int        cyc;
  bit        acc_ok;
  int        idx;
  resp_t     ent;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      m_running = 1'b0;
    end else begin
      cyc    = cyc + 1;
      acc_ok = m_running && (q.size() < RESP_DEPTH);
      if (q.size() > 0 && q[0].avail <= cyc - 1 && rdy) void'(q.pop_front());
      if (acc_ok && (wr || rd)) begin
        idx = int'(addr[ADDR_BITS+1:2]);
        if (wr) begin
          for (int i = 0; i < 4; i++)
            if (be[i]) mmem[idx][8*i +: 8] = wdata[8*i +: 8];
          if (be == 4'hF) mknown[idx] = 1'b1;
        end
        if (rd) begin
          ent.data  = mmem[idx];
          ent.known = mknown[idx];
          ent.avail = cyc + 1;
          q.push_back(ent);
        end
      end
      m_running = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [31:0] got[$];
  bit          exp_valid;
  bit          exp_ready;

  always @(negedge clk) begin
    exp_ready = m_running && (q.size() < RESP_DEPTH);
    exp_valid = (q.size() > 0) && (q[0].avail <= cyc);
    check("ready", {31'b0, bus_ready}, {31'b0, exp_ready});
    check("valid", {31'b0, rvalid}, {31'b0, exp_valid});
    if (exp_valid && q[0].known) check("read_data", rdata, q[0].data);
    if (rvalid && rdy) got.push_back(rdata);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_accept(input string name);
    bit ok;
    bit done;
    done = 1'b0;
    for (int n = 0; n < 50 && !done; n++) begin
      ok = bus_ready;
      tick();
      if (ok) done = 1'b1;
    end
    if (!done) begin
      errors++;
      $display("FAIL %s: request not accepted within 50 cycles", name);
    end
  endtask

  task automatic do_write(input logic [31:2] a, input logic [31:0] d, input logic [3:0] b);
    addr = a; wdata = d; be = b; wr = 1'b1; rd = 1'b0;
    wait_accept("write_accept");
    wr = 1'b0;
  endtask

  task automatic do_read(input logic [31:2] a, output logic [31:0] d);
    int base;
    base = got.size();
    addr = a; rd = 1'b1; wr = 1'b0;
    wait_accept("read_accept");
    rd = 1'b0;
    for (int n = 0; n < 20 && got.size() <= base; n++) tick();
    if (got.size() <= base) begin
      errors++;
      $display("FAIL read_response: none within 20 cycles, got 0 entries expected 1");
      d = '0;
    end else begin
      d = got[base];
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  logic [31:0] d;
  int          base;
  int          next;
  int          accepted;
  bit          ok;
  bit          never_low;
  logic [31:2] issued[$];

  initial begin
    checks = 0; errors = 0; cyc = 0;
    reset = 1'b0; rd = 1'b0; wr = 1'b0; rdy = 1'b0;
    addr = '0; be = '0; wdata = '0;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("reset_ready", {31'b0, bus_ready}, 32'd0);
    check("reset_valid", {31'b0, rvalid}, 32'd0);
    reset = 1'b0;
    #1 check("ready_before_first_edge", {31'b0, bus_ready}, 32'd0);
    tick();
    check("ready_after_first_edge", {31'b0, bus_ready}, 32'd1);

    // Full write then read with latency pinned.
    rdy = 1'b1;
    do_write(30'h10, 32'hDEADBEEF, 4'hF);
    addr = 30'h10; rd = 1'b1;
    tick();
    rd = 1'b0;
    @(negedge clk);
    check("latency_valid_t", {31'b0, rvalid}, 32'd0);
    @(negedge clk);
    check("latency_valid_t1", {31'b0, rvalid}, 32'd1);
    check("latency_data", rdata, 32'hDEADBEEF);
    tick();

    // Byte lanes and the empty byte enable.
    do_write(30'h44, 32'h11223344, 4'hF);
    do_write(30'h44, 32'hAABBCCDD, 4'b0101);
    do_read(30'h44, d);
    check("byte_lanes", d, 32'h11BB33DD);
    do_write(30'h44, 32'hFFFFFFFF, 4'b0000);
    do_read(30'h44, d);
    check("be_zero", d, 32'h11BB33DD);

    // Write-first, read-after-write, aliasing.
    addr = 30'h20; wdata = 32'h0000CAFE; be = 4'hF; wr = 1'b1; rd = 1'b1;
    base = got.size();
    wait_accept("wr_rd_accept");
    wr = 1'b0; rd = 1'b0;
    for (int n = 0; n < 20 && got.size() <= base; n++) tick();
    check("write_first", (got.size() > base) ? got[base] : 32'hX, 32'h0000CAFE);
    do_write(30'h30, 32'h0BADF00D, 4'hF);
    do_read(30'h30, d);
    check("read_after_write", d, 32'h0BADF00D);
    do_write(30'((1 << ADDR_BITS) + 3), 32'h12345678, 4'hF);
    do_read(30'h3, d);
    check("alias", d, 32'h12345678);

    // Credit limit with the consumer stalled.
    for (int i = 0; i < 6; i++) do_write(30'(i), 32'h100 + i, 4'hF);
    rdy = 1'b0;
    base = got.size();
    next = 0;
    for (int c = 0; c < 12; c++) begin
      if (next < 6) begin rd = 1'b1; addr = 30'(next); end else rd = 1'b0;
      ok = bus_ready && rd;
      tick();
      if (ok) next++;
    end
    check("credit_accepted", 32'(next), 32'd4);
    check("credit_ready_low", {31'b0, bus_ready}, 32'd0);
    rdy = 1'b1;
    for (int c = 0; c < 30 && next < 6; c++) begin
      rd = 1'b1; addr = 30'(next);
      ok = bus_ready;
      tick();
      if (ok) next++;
    end
    rd = 1'b0;
    for (int n = 0; n < 20 && got.size() < base + 6; n++) tick();
    check("credit_count", 32'(got.size() - base), 32'd6);
    for (int i = 0; i < 6; i++)
      check("credit_order", (got.size() > base + i) ? got[base + i] : 32'hX, 32'h100 + i);

    // Sustained back-to-back reads.
    for (int i = 0; i < 8; i++) do_write(30'h40 + 30'(i), 32'hC0DE0000 + i, 4'hF);
    base = got.size();
    accepted = 0; never_low = 1'b1;
    issued.delete();
    for (int c = 0; c < 16; c++) begin
      rd = 1'b1; addr = 30'h40 + 30'(c % 8);
      if (!bus_ready) never_low = 1'b0;
      ok = bus_ready;
      tick();
      if (ok) begin accepted++; issued.push_back(addr); end
    end
    rd = 1'b0;
    check("stream_accepted", 32'(accepted), 32'd16);
    check("stream_ready_high", {31'b0, never_low}, 32'd1);
    check("stream_resp_rate", 32'(got.size() - base), 32'd14);
    for (int n = 0; n < 20 && got.size() < base + 16; n++) tick();
    for (int i = 0; i < 16; i++)
      check("stream_data", (got.size() > base + i) ? got[base + i] : 32'hX, 32'hC0DE0000 + (i % 8));

    // Reset with reads buffered and in flight.
    rdy = 1'b0;
    addr = 30'h10; rd = 1'b1;
    repeat (3) tick();
    rd = 1'b0;
    check("pre_reset_valid", {31'b0, rvalid}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_reset_valid", {31'b0, rvalid}, 32'd0);
    check("mid_reset_ready", {31'b0, bus_ready}, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    #1 check("release_ready_low", {31'b0, bus_ready}, 32'd0);
    tick();
    check("release_ready_high", {31'b0, bus_ready}, 32'd1);
    rdy = 1'b1;
    base = got.size();
    repeat (8) tick();
    check("no_stale", 32'(got.size() - base), 32'd0);
    do_read(30'h10, d);
    check("mem_kept", d, 32'hDEADBEEF);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
